// File: rtl/padded_raster_pkg.sv
// Shared types and defaults for the padded raster scanner: FSM states,
// latched frame configuration and the padded-extent helper.
package padded_raster_pkg;

  localparam int DEF_CNT_W   = 15;
  localparam int DEF_PAD_W   = 2;
  localparam int DEF_MAX_W   = 640;
  localparam int DEF_MAX_H   = 640;
  localparam int DEF_MAX_PAD = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] width;
    logic [DEF_CNT_W-1:0] height;
    logic [DEF_PAD_W-1:0] pad;
  } cfg_t;

  // Index of the last padded position along one axis: extent + 2*pad - 1.
  function automatic int padded_last(input int extent, input int pad);
    return extent + 2 * pad - 1;
  endfunction

endpackage

// File: rtl/padded_axis_counter.sv
// One axis (column or row) of the padded scan: wrapping position counter
// with last-index and padding-border detection against the latched geometry.
module padded_axis_counter
  import padded_raster_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PAD_W = DEF_PAD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] extent,
  input  logic [PAD_W-1:0] depth,
  output logic [CNT_W-1:0] cnt,
  output logic             is_last,
  output logic             in_pad
);

  logic [CNT_W-1:0] depth_ext;
  logic [CNT_W-1:0] body_end;

  always_comb begin
    depth_ext = CNT_W'(depth);
    body_end  = depth_ext + extent;
    is_last   = (cnt == limit);
    // Border on the low side below depth, on the high side from depth+extent.
    in_pad    = (cnt < depth_ext) || (cnt >= body_end);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= is_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/padded_raster_scanner.sv
// Run-time configurable 2-D padded frame scanner: steps one padded position
// per valid/ready handshake and flags padding plus row/frame boundaries.
module padded_raster_scanner
  import padded_raster_pkg::*;
#(
  parameter int MAX_W   = DEF_MAX_W,
  parameter int MAX_H   = DEF_MAX_H,
  parameter int MAX_PAD = DEF_MAX_PAD,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PAD_W   = DEF_PAD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_height,
  input  logic [PAD_W-1:0] cfg_pad,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] pcol,
  output logic [CNT_W-1:0] prow,
  output logic             pad,
  output logic             first_col,
  output logic             last_col,
  output logic             last_pos,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  if (MAX_W + 2 * MAX_PAD > (1 << CNT_W) - 1) begin : g_bad_width
    $error("padded_raster_scanner: MAX_W + 2*MAX_PAD does not fit in CNT_W");
  end
  if (MAX_H + 2 * MAX_PAD > (1 << CNT_W) - 1) begin : g_bad_height
    $error("padded_raster_scanner: MAX_H + 2*MAX_PAD does not fit in CNT_W");
  end
  if (MAX_PAD > (1 << PAD_W) - 1) begin : g_bad_pad
    $error("padded_raster_scanner: PAD_W cannot hold MAX_PAD");
  end
  if (CNT_W > DEF_CNT_W || PAD_W > DEF_PAD_W) begin : g_bad_cfg_store
    $error("padded_raster_scanner: CNT_W/PAD_W exceed the cfg_t field widths");
  end

  // Handshake: a position transfers on a clock edge where out_valid and
  // out_ready are both high; while out_ready is low the position and every
  // flag hold, and out_valid never drops until the transfer happens.

  state_t           state_q;
  state_t           state_d;
  cfg_t             cfg_q;
  cfg_t             cfg_in;
  logic [CNT_W-1:0] col_limit_q;
  logic [CNT_W-1:0] row_limit_q;
  logic             frame_done_q;
  logic             cfg_err_q;

  logic [CNT_W-1:0] pad_ext;
  logic             cfg_ok;
  logic             accept;
  logic             reject;
  logic             handshake;
  logic             final_hs;
  logic             row_inc;
  logic             counter_clear;

  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             col_last;
  logic             row_last;
  logic             col_pad;
  logic             row_pad;

  always_comb begin
    pad_ext       = CNT_W'(cfg_pad);
    cfg_ok        = (cfg_width != '0) && (cfg_width <= CNT_W'(MAX_W)) &&
                    (cfg_height != '0) && (cfg_height <= CNT_W'(MAX_H)) &&
                    (pad_ext <= CNT_W'(MAX_PAD));
    cfg_in.width  = DEF_CNT_W'(cfg_width);
    cfg_in.height = DEF_CNT_W'(cfg_height);
    cfg_in.pad    = DEF_PAD_W'(cfg_pad);
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    handshake = 1'b0;
    final_hs  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept  = 1'b1;
            state_d = SCAN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SCAN: begin
        handshake = out_ready;
        if (out_ready && col_last && row_last) begin
          final_hs = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      col_limit_q  <= '0;
      row_limit_q  <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= final_hs;
      cfg_err_q    <= reject;
      if (accept) begin
        cfg_q       <= cfg_in;
        // Last padded indices are fixed for the whole frame, so compute once.
        col_limit_q <= CNT_W'(padded_last(int'(cfg_width), int'(cfg_pad)));
        row_limit_q <= CNT_W'(padded_last(int'(cfg_height), int'(cfg_pad)));
      end
    end
  end

  // Both counters restart on an accepted start and after the final transfer,
  // so the idle position always reads (0,0).
  assign counter_clear = accept || final_hs;
  assign row_inc       = handshake && col_last;

  padded_axis_counter #(
    .CNT_W (CNT_W),
    .PAD_W (PAD_W)
  ) u_col (
    .clk     (clk),
    .reset   (reset),
    .clear   (counter_clear),
    .inc     (handshake),
    .limit   (col_limit_q),
    .extent  (CNT_W'(cfg_q.width)),
    .depth   (PAD_W'(cfg_q.pad)),
    .cnt     (col_cnt),
    .is_last (col_last),
    .in_pad  (col_pad)
  );

  padded_axis_counter #(
    .CNT_W (CNT_W),
    .PAD_W (PAD_W)
  ) u_row (
    .clk     (clk),
    .reset   (reset),
    .clear   (counter_clear),
    .inc     (row_inc),
    .limit   (row_limit_q),
    .extent  (CNT_W'(cfg_q.height)),
    .depth   (PAD_W'(cfg_q.pad)),
    .cnt     (row_cnt),
    .is_last (row_last),
    .in_pad  (row_pad)
  );

  always_comb begin
    out_valid  = (state_q == SCAN);
    busy       = (state_q == SCAN);
    pcol       = col_cnt;
    prow       = row_cnt;
    pad        = out_valid && (col_pad || row_pad);
    first_col  = out_valid && (col_cnt == '0);
    last_col   = out_valid && col_last;
    last_pos   = out_valid && col_last && row_last;
    frame_done = frame_done_q;
    cfg_err    = cfg_err_q;
  end

endmodule

// File: tb/tb_padded_raster_scanner.sv
// Scoreboard bench for padded_raster_scanner: a row-major frame model fills
// the expected queue, a negedge monitor pops and compares on every transfer.
module tb_padded_raster_scanner;

  localparam int CNT_W   = 15;
  localparam int PAD_W   = 2;
  localparam int MAX_W   = 640;
  localparam int MAX_H   = 640;
  localparam int MAX_PAD = 3;
  localparam int EW      = 2 * CNT_W + 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_width = '0;
  logic [CNT_W-1:0] cfg_height = '0;
  logic [PAD_W-1:0] cfg_pad = '0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [CNT_W-1:0] pcol;
  logic [CNT_W-1:0] prow;
  logic             pad;
  logic             first_col;
  logic             last_col;
  logic             last_pos;
  logic             busy;
  logic             frame_done;
  logic             cfg_err;

  int errors = 0;
  int checks = 0;
  bit rnd_ready = 1'b0;

  logic [EW-1:0] exp_q[$];

  padded_raster_scanner #(
    .MAX_W   (MAX_W),
    .MAX_H   (MAX_H),
    .MAX_PAD (MAX_PAD),
    .CNT_W   (CNT_W),
    .PAD_W   (PAD_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_pad    (cfg_pad),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .pcol       (pcol),
    .prow       (prow),
    .pad        (pad),
    .first_col  (first_col),
    .last_col   (last_col),
    .last_pos   (last_pos),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Reference model: row-major walk of the (W+2P) x (H+2P) frame.
  task automatic push_frame(input int w, input int h, input int p);
    int pw;
    int ph;
    bit in_pad;
    pw = w + 2 * p;
    ph = h + 2 * p;
    for (int r = 0; r < ph; r++) begin
      for (int c = 0; c < pw; c++) begin
        in_pad = (c < p) || (c >= p + w) || (r < p) || (r >= p + h);
        exp_q.push_back({CNT_W'(c), CNT_W'(r), in_pad, (c == 0), (c == pw - 1),
                         (c == pw - 1) && (r == ph - 1)});
      end
    end
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_frame(input int w, input int h, input int p);
    bit ok;
    ok = (w >= 1) && (w <= MAX_W) && (h >= 1) && (h <= MAX_H) && (p <= MAX_PAD);
    cfg_width  = CNT_W'(w);
    cfg_height = CNT_W'(h);
    cfg_pad    = PAD_W'(p);
    start      = 1'b1;
    if (ok) push_frame(w, h, p);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ok) begin
      check("start_latency_valid", out_valid, 1);
      check("start_busy", busy, 1);
    end else begin
      check("cfg_err_pulse", cfg_err, 1);
      check("reject_stays_idle", busy, 0);
      @(posedge clk);
      #1;
      check("cfg_err_one_cycle", cfg_err, 0);
      check("reject_no_valid", out_valid, 0);
    end
  endtask

  // Returns in the frame_done cycle, so a following start_frame is back-to-back.
  task automatic wait_done(input int budget, input bit spurious);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      if (spurious && exp_q.size() > 4) begin
        start      = 1'($urandom_range(0, 1));
        cfg_width  = CNT_W'($urandom_range(0, 700));
        cfg_height = CNT_W'($urandom_range(0, 700));
        cfg_pad    = PAD_W'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (spurious) check("no_cfg_err_while_busy", cfg_err, 0);
      if (frame_done) got = 1'b1;
    end
    start = 1'b0;
    check("frame_done_seen", got, 1);
    check("all_positions_consumed", exp_q.size(), 0);
  endtask

  // Monitor / scoreboard
  logic [EW-1:0] obs;
  logic [EW-1:0] prev_obs = '0;
  logic [EW-1:0] e;
  bit            hold_prev = 1'b0;
  bit            done_exp = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 1'b0;
        done_exp  = 1'b0;
      end else begin
        obs = {pcol, prow, pad, first_col, last_col, last_pos};
        check("frame_done_timing", frame_done, done_exp);
        done_exp = 1'b0;
        check("busy_matches_valid", busy, out_valid);
        if (hold_prev && out_valid) check("stable_under_backpressure", obs, prev_obs);
        if (!out_valid) begin
          check("idle_outputs_zero", obs, 0);
        end else if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_position", obs, 0 - 1);
          end else begin
            e = exp_q.pop_front();
            check("position_and_flags", obs, e);
            done_exp = e[0];
          end
        end
        hold_prev = out_valid && !out_ready;
        prev_obs  = obs;
      end
    end
  end

  // Main sequence
  bit found;

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_pcol", pcol, 0);
    check("reset_prow", prow, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_cfg_err", cfg_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Small frame, full throughput
    rnd_ready = 1'b0;
    start_frame(4, 3, 1);
    wait_done(200, 1'b0);

    // Backpressure, back-to-back with the previous frame
    rnd_ready = 1'b1;
    start_frame(5, 2, 2);
    wait_done(1000, 1'b0);

    // Single-position frame
    rnd_ready = 1'b0;
    start_frame(1, 1, 0);
    wait_done(20, 1'b0);

    // Rejected configurations
    @(posedge clk);
    #1;
    start_frame(0, 3, 1);
    start_frame(641, 3, 1);
    start_frame(4, 0, 1);
    start_frame(4, 641, 0);

    // Largest accepted width
    start_frame(640, 1, 3);
    wait_done(6000, 1'b0);

    // Start requests while busy must be ignored
    rnd_ready = 1'b1;
    start_frame(6, 3, 1);
    wait_done(2000, 1'b1);

    // Reset mid-frame at (3,2)
    rnd_ready = 1'b0;
    start_frame(8, 5, 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && pcol == CNT_W'(3) && prow == CNT_W'(2)) found = 1'b1;
    end
    check("reached_3_2", found, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pcol", pcol, 0);
    check("abort_prow", prow, 0);
    check("abort_frame_done", frame_done, 0);
    check("abort_pad", pad, 0);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("no_done_after_abort", frame_done, 0);
    check("idle_after_abort", busy, 0);
    start_frame(3, 2, 1);
    wait_done(200, 1'b0);

    // Randomized frames, each started in the previous frame_done cycle
    for (int k = 0; k < 8; k++) begin
      rnd_ready = 1'($urandom_range(0, 1));
      start_frame($urandom_range(1, 12), $urandom_range(1, 6), $urandom_range(0, 3));
      wait_done(2000, 1'(k % 2));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/padded_raster_scanner.md
Name: padded_raster_scanner

Overview:
- Parametrised successor to the fixed 640-column padded counter: scans a full 2-D padded frame (columns and rows) instead of one hard-wired row length.
- Frame width, height and pad depth are set at run time.
- Steps one padded position per valid/ready handshake and flags padding positions plus row/frame boundaries.
- Sits ahead of the conv line-buffer/window logic and drives pixel-fetch addressing and zero-injection.

Parameters:
- MAX_W, 640, largest image width accepted.
- MAX_H, 640, largest image height accepted.
- MAX_PAD, 3, largest pad depth per side.
- CNT_W, 15, counter/coordinate width. Elaboration error if MAX_W+2*MAX_PAD or MAX_H+2*MAX_PAD exceeds 2^CNT_W-1.
- PAD_W, 2, width of cfg_pad. Must hold MAX_PAD.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- cfg_width  in  CNT_W  image width W, latched on accepted start
- cfg_height  in  CNT_W  image height H, latched on accepted start
- cfg_pad  in  PAD_W  pad depth P per side, latched on accepted start
- out_ready  in  1  consumer accepts current position
- out_valid  out  1  current position valid
- pcol  out  CNT_W  padded column, 0..W+2P-1
- prow  out  CNT_W  padded row, 0..H+2P-1
- pad  out  1  current position lies in the padding border
- first_col  out  1  pcol==0
- last_col  out  1  pcol==W+2P-1
- last_pos  out  1  last_col && prow==H+2P-1
- busy  out  1  state==SCAN
- frame_done  out  1  one-cycle pulse after the final handshake
- cfg_err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset, at the next clk edge: state=IDLE; pcol=prow=0; out_valid, busy, frame_done and cfg_err all 0; latched cfg=0. A reset mid-frame aborts with no frame_done.
- States: IDLE, SCAN.
- IDLE, start=1, cfg valid (1<=W<=MAX_W, 1<=H<=MAX_H, P<=MAX_PAD): latch cfg, pcol=prow=0, go SCAN. out_valid=1 on the following cycle, i.e. latency 1.
- IDLE, start=1, cfg invalid: stay IDLE and pulse cfg_err for 1 cycle.
- SCAN: out_valid=1 continuously. Advance only on out_valid&&out_ready.
  - Position and all flags hold stable while out_ready=0.
- Advance rule:
  - pcol<PW-1: pcol+1.
  - Otherwise pcol=0, and if prow<PH-1 then prow+1.
  - PW=W+2P, PH=H+2P.
- Final handshake (last_pos): go IDLE. Next cycle: out_valid=0, busy=0, frame_done=1, pcol=prow=0.
  - start in that cycle is accepted, giving a back-to-back frame with a 1-cycle bubble.
- start while in SCAN is ignored. cfg inputs are don't-care outside an accepted start.
- pad, first_col, last_col and last_pos are combinational from the registered pcol/prow and latched cfg:
  - pad = pcol<P | pcol>=P+W | prow<P | prow>=P+H.
  - All flags are 0 when out_valid=0.
- P=0: pad is never set; the scan is plain W x H.
- W=1, P=0: first_col and last_col are both 1 at every position.
- Arithmetic: unsigned, CNT_W bits. PW-1 and PH-1 are computed once at latch time into registers, with no wrap by construction.

Decomposition:
- Package padded_raster_pkg holds:
  - the state enum (IDLE, SCAN);
  - default CNT_W, MAX_W, MAX_H, MAX_PAD;
  - a cfg struct {width, height, pad}.
- Sub-module padded_axis_counter, instantiated twice (column, row). Ports:
  - clk, reset, clear, inc, limit;
  - cnt, is_last, in_pad.
- The column instance increments on handshake. The row instance increments on handshake && col is_last.
- The top level holds only the FSM, cfg latch, validation and flag gating.

Test Plan:
- Default frame: W=H=640, P=1, out_ready=1.
  - Exactly 642*642=412164 handshakes.
  - pad=1 on rows 0/641 and cols 0/641 only.
  - frame_done pulses once, 1 cycle after pcol=prow=641.
- Small frame: W=4, H=3, P=1.
  - Scan order is row-major over 6x5.
  - pad=0 exactly at pcol 1..4, prow 1..3, i.e. 12 interior positions.
  - last_col at pcol=5; last_pos at (5,4).
- Backpressure: random out_ready with 50% duty on W=5, H=2, P=2.
  - pcol/prow/flags never change while out_ready=0.
  - 9*6=54 handshakes total.
- Config edges:
  - W=0 -> cfg_err pulse, stays IDLE.
  - W=641 -> cfg_err pulse, stays IDLE.
  - P=0, W=1, H=1 -> single position, pad=0, first_col=last_col=last_pos=1, then frame_done.
- Reset mid-frame: reset at (pcol=3, prow=2).
  - Next cycle all outputs 0, state IDLE, no frame_done.
  - A new start then scans from (0,0).
- Start while busy is ignored. Start in the frame_done cycle begins a new frame whose out_valid rises the next cycle.
